// File: rtl/accdnn_pkg.sv
// ============================================================================
// accdnn_pkg : shared helpers for the accelerator datapath blocks
// Rev 1.0    : clog2, pipeline-depth helpers, round/shift/saturate
// ============================================================================
`default_nettype none

package accdnn_pkg;

  localparam int MAXW = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int tl_of(input int cpf);
    return clog2(cpf);
  endfunction

  function automatic int lat_of(input int cpf);
    return clog2(cpf) + 3;
  endfunction

  // Rounds (half up) or floors by sh bits, then clamps to a signed out_w range.
  function automatic logic signed [MAXW-1:0] round_sat(
    input logic signed [MAXW-1:0] v,
    input int                     sh,
    input bit                     rnd,
    input int                     out_w,
    input bit                     relu
  );
    logic signed [MAXW-1:0] one, hi, lo, r;
    one = MAXW'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    r   = v;
    if (rnd && sh > 0) r = r + (one <<< (sh - 1));
    r = r >>> sh;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    if (relu && r < 0) r = '0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vect_add_tree.sv
// ============================================================================
// vect_add_tree : N-input pipelined signed adder tree with aligned sideband
// Rev 1.0       : one register level per halving, 1-bit growth per level
// ============================================================================
`default_nettype none

module vect_add_tree
  import accdnn_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  IN_W  = 16,
  parameter int  SB_W  = 3,
  localparam int TL    = clog2(N),
  localparam int OUT_W = IN_W + TL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*IN_W-1:0] din,
  input  logic [SB_W-1:0]   din_sb,
  output logic [OUT_W-1:0]  dout,
  output logic [SB_W-1:0]   dout_sb
);

  // Every level is kept at the final width so that sign extension happens once.
  for (genvar l = 0; l <= TL; l++) begin : g_lvl
    localparam int CNT = N >> l;
    logic [CNT*OUT_W-1:0] data;
    logic [SB_W-1:0]      sb;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_ext
        assign data[i*OUT_W +: OUT_W] = OUT_W'($signed(din[i*IN_W +: IN_W]));
      end
      assign sb = din_sb;
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data <= '0;
          sb   <= '0;
        end else begin
          for (int k = 0; k < CNT; k++) begin
            data[k*OUT_W +: OUT_W] <= g_lvl[l-1].data[(2*k)*OUT_W +: OUT_W]
                                    + g_lvl[l-1].data[(2*k+1)*OUT_W +: OUT_W];
          end
          sb <= g_lvl[l-1].sb;
        end
      end
    end
  end

  assign dout    = g_lvl[TL].data[OUT_W-1:0];
  assign dout_sb = g_lvl[TL].sb;

endmodule

`default_nettype wire

// File: rtl/vect_mac_array.sv
// ============================================================================
// vect_mac_array : multi-channel vector MAC with bias, round, saturate, ReLU
// Rev 1.0        : M -> T(tree) -> A(accumulate) -> P(post-process) pipeline
// ============================================================================
`default_nettype none

module vect_mac_array
  import accdnn_pkg::*;
#(
  parameter int CPF          = 32,
  parameter int DATA_CHANNEL = 2,
  parameter int DIN_DW       = 8,
  parameter int DIN_Q        = 2,
  parameter int WW           = 8,
  parameter int WQ           = 8,
  parameter int BIAS_DW      = 16,
  parameter int BIAS_Q       = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int DOUT_DW      = 8,
  parameter int DOUT_Q       = 1,
  parameter int ROUND        = 1,
  parameter int RELU         = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_din_en,
  input  logic                            op_din_eop,
  input  logic [DIN_DW*CPF-1:0]           op_din,
  input  logic [WW*DATA_CHANNEL*CPF-1:0]  op_weight,
  input  logic [BIAS_DW*DATA_CHANNEL-1:0] op_bias,
  output logic                            op_dout_en,
  output logic [DOUT_DW*DATA_CHANNEL-1:0] op_dout
);

  localparam int TL   = tl_of(CPF);
  localparam int PW   = DIN_DW + WW;
  localparam int SW   = PW + TL;
  localparam int QS   = DIN_Q + WQ;
  localparam int BSH  = QS - BIAS_Q;
  localparam int SH   = QS - DOUT_Q;
  localparam int SB_W = 3 + BIAS_DW;

  if (BIAS_Q > QS) begin : g_chk_bias_q
    $error("BIAS_Q must not exceed DIN_Q+WQ");
  end
  if (DOUT_Q > QS) begin : g_chk_dout_q
    $error("DOUT_Q must not exceed DIN_Q+WQ");
  end
  if (CPF < 1 || (CPF & (CPF - 1)) != 0) begin : g_chk_cpf
    $error("CPF must be a power of 2");
  end

  logic                                    in_pkt;
  logic [DATA_CHANNEL-1:0][CPF*PW-1:0]     prod_c;
  logic [DATA_CHANNEL-1:0][CPF*PW-1:0]     prod_q;
  logic [DATA_CHANNEL-1:0][SB_W-1:0]       sb_q;
  logic [DATA_CHANNEL-1:0]                 ch_en;

  always_comb begin
    prod_c = '0;
    for (int c = 0; c < DATA_CHANNEL; c++) begin
      for (int i = 0; i < CPF; i++) begin
        prod_c[c][i*PW +: PW] = PW'($signed(op_din[i*DIN_DW +: DIN_DW]))
                              * PW'($signed(op_weight[(c*CPF+i)*WW +: WW]));
      end
    end
  end

  // Stage M. Sideband = {bias, eop, first, valid}; bias rides along so that
  // back-to-back packets each keep their own EOP-beat bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt <= 1'b0;
      prod_q <= '0;
      sb_q   <= '0;
    end else begin
      if (op_din_en) begin
        in_pkt <= !op_din_eop;
        prod_q <= prod_c;
      end
      for (int c = 0; c < DATA_CHANNEL; c++) begin
        sb_q[c] <= {op_bias[c*BIAS_DW +: BIAS_DW], op_din_en & op_din_eop,
                    op_din_en & !in_pkt, op_din_en};
      end
    end
  end

  for (genvar c = 0; c < DATA_CHANNEL; c++) begin : g_ch
    logic [SW-1:0]                 tsum;
    logic [SB_W-1:0]               tsb;
    logic signed [ACC_WIDTH-1:0]   sum_ext;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [BIAS_DW-1:0]     acc_bias;
    logic                          done;
    logic signed [MAXW-1:0]        wide;
    logic [DOUT_DW-1:0]            dout_q;
    logic                          en_q;

    vect_add_tree #(
      .N    (CPF),
      .IN_W (PW),
      .SB_W (SB_W)
    ) u_tree (
      .clk     (clk),
      .rst     (rst),
      .din     (prod_q[c]),
      .din_sb  (sb_q[c]),
      .dout    (tsum),
      .dout_sb (tsb)
    );

    assign sum_ext = ACC_WIDTH'($signed(tsum));

    // Stage A: wraps modulo 2^ACC_WIDTH by construction.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc      <= '0;
        acc_bias <= '0;
        done     <= 1'b0;
      end else begin
        done <= tsb[0] & tsb[2];
        if (tsb[0]) begin
          acc <= tsb[1] ? sum_ext : acc + sum_ext;
          if (tsb[2]) acc_bias <= tsb[SB_W-1 -: BIAS_DW];
        end
      end
    end

    always_comb begin
      wide = MAXW'(acc) + (MAXW'(acc_bias) <<< BSH);
    end

    // Stage P
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q   <= 1'b0;
        dout_q <= '0;
      end else begin
        en_q <= done;
        if (done) dout_q <= DOUT_DW'(round_sat(wide, SH, ROUND != 0, DOUT_DW, RELU != 0));
      end
    end

    assign op_dout[c*DOUT_DW +: DOUT_DW] = dout_q;
    assign ch_en[c] = en_q;
  end

  assign op_dout_en = &ch_en;

endmodule

`default_nettype wire

// File: tb/tb_vect_mac_array.sv
// ============================================================================
// tb_vect_mac_array : scoreboard bench driving four differently-configured DUTs
// Rev 1.0           : CPF=4, 2 channels, 8-bit data; Q/ROUND/RELU varied per DUT
// ============================================================================
`default_nettype none

module tb_vect_mac_array;
  import accdnn_pkg::*;

  localparam int LAT = lat_of(4);
  localparam int DQ  [4] = '{0, 1, 1, 0};
  localparam int RND [4] = '{1, 1, 0, 1};
  localparam int RLU [4] = '{0, 0, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_en = 1'b0;
  logic        din_eop = 1'b0;
  logic [31:0] din = '0;
  logic [63:0] wgt = '0;
  logic [31:0] bias = '0;
  logic [3:0]        en_all;
  logic [3:0][15:0]  dout_all;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    vect_mac_array #(
      .CPF(4), .DATA_CHANNEL(2), .DIN_DW(8), .DIN_Q(DQ[k]), .WW(8), .WQ(0),
      .BIAS_DW(16), .BIAS_Q(0), .ACC_WIDTH(40), .DOUT_DW(8), .DOUT_Q(0),
      .ROUND(RND[k]), .RELU(RLU[k])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .op_din_en  (din_en),
      .op_din_eop (din_eop),
      .op_din     (din),
      .op_weight  (wgt),
      .op_bias    (bias),
      .op_dout_en (en_all[k]),
      .op_dout    (dout_all[k])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int                     due;
    logic [3:0][1:0][7:0]   v;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  longint macc[2];
  bit     in_pkt = 1'b0;

  function automatic logic [7:0] model_out(input longint s, input int b, input int dq,
                                           input int rnd, input int relu);
    longint v;
    v = s + (longint'(b) <<< dq);
    if (rnd != 0 && dq > 0) v = v + (longint'(1) <<< (dq - 1));
    v = v >>> dq;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu != 0 && v < 0) v = 0;
    return v[7:0];
  endfunction

  // Called right after a rising edge; the beat is sampled on the next edge.
  task automatic beat(input logic [31:0] d, input logic [63:0] w, input logic [31:0] b,
                      input bit eop);
    exp_t   e;
    longint dot;
    din_en = 1'b1; din = d; wgt = w; bias = b; din_eop = eop;
    for (int c = 0; c < 2; c++) begin
      dot = 0;
      for (int i = 0; i < 4; i++)
        dot += longint'($signed(d[i*8 +: 8])) * longint'($signed(w[(c*4+i)*8 +: 8]));
      macc[c] = in_pkt ? macc[c] + dot : dot;
    end
    in_pkt = !eop;
    if (eop) begin
      e.due = cyc + LAT;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 2; c++)
          e.v[k][c] = model_out(macc[c], $signed(b[c*16 +: 16]), DQ[k], RND[k], RLU[k]);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    din_en = 1'b0; din_eop = 1'b0;
  endtask

  task automatic idle(input int n, input bit eop_noise);
    repeat (n) begin
      din_eop = eop_noise;
      @(posedge clk); #1;
    end
    din_eop = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sbq.size() > 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (en_all != 4'b0) begin
        if (sbq.size() == 0) begin
          check("spurious_en", en_all, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("en_all", en_all, 4'hF);
          check("latency", cyc, mon_e.due);
          for (int k = 0; k < 4; k++)
            for (int c = 0; c < 2; c++)
              check($sformatf("dut%0d_ch%0d", k, c), $signed(dout_all[k][c*8 +: 8]),
                    $signed(mon_e.v[k][c]));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check("missing_en", en_all, 4'hF);
        sbq.delete(0);
      end
    end
  end

  localparam logic [31:0] ONES = 32'h01010101;
  localparam logic [63:0] W1   = 64'h0101010101010101;

  initial begin
    logic [7:0] kb;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_en", en_all, 0);
    check("reset_dout", dout_all, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-beat packet
    beat(ONES, W1, 32'h0, 1'b0);
    beat(ONES, W1, 32'h0, 1'b1);
    drain();

    // Saturation: ch0 large positive, ch1 large negative
    beat(32'h7f7f7f7f, {32'h80808080, 32'h7f7f7f7f}, 32'h0, 1'b1);
    drain();

    // Rounding: ch0 sees +3, ch1 sees -3
    beat(32'h0000fd03, 64'h0000_0100_0000_0001, 32'h0, 1'b1);
    drain();

    // Bias with bubbles; stray EOP without a valid beat must be ignored
    beat(ONES, W1, 32'hffec0005, 1'b0);
    idle(2, 1'b1);
    beat(ONES, W1, 32'hffec0005, 1'b0);
    idle(2, 1'b1);
    beat(ONES, W1, 32'hffec0005, 1'b1);
    drain();

    // Back-to-back single-beat packets
    for (int k = 1; k <= 4; k++) begin
      kb = 8'(k);
      beat({4{kb}}, W1, 32'h0, 1'b1);
    end
    drain();

    // Reset in the middle of a packet
    beat(ONES, W1, 32'h0, 1'b0);
    rst = 1'b1;
    in_pkt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_en", en_all, 0);
    check("midrst_dout", dout_all, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    beat(32'h02020202, W1, 32'h0, 1'b1);
    drain();

    repeat (LAT + 4) @(posedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
